alu_result_stage: RTL and testbench

ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

---
 rtl/alu_result_stage_pkg.sv | 33 +++
 rtl/alu_result_stage_result_fifo2.sv | 57 +++++
 rtl/alu_result_stage.sv | 110 +++++++++++
 tb/tb_alu_result_stage.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_result_stage_pkg.sv
// rtl/alu_result_stage_pkg.sv - shared ALU control codes, result-stage state encoding and defaults
package alu_result_stage_pkg;

    // ALU control codes shared with the ALU and decoder.
    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLT,
        ALU_SLL,
        ALU_SRL,
        ALU_SRA,
        ALU_MUL,
        ALU_DIV
    } alu_ctrl_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } stage_state_e;

    localparam int MULDIV_WAIT_DEFAULT = 3;

    // Buffer entry layout: {hi[31:0], lo[31:0], zero, neg}
    localparam int RESULT_W = 66;

    function automatic logic is_muldiv(input logic [3:0] ctrl);
        return (ctrl == ALU_MUL) || (ctrl == ALU_DIV);
    endfunction

endpackage

// File: rtl/alu_result_stage_result_fifo2.sv
// rtl/alu_result_stage_result_fifo2.sv - 2-entry in-order result buffer
// Ports: clk, resetn (sync active-low); push/push_data write an entry,
// pop removes the head; head_data is the head entry (0 when empty);
// full/empty report occupancy. A push while full only lands if the
// same cycle also pops.
module result_fifo2
    import alu_result_stage_pkg::*;
#(
    parameter int W = RESULT_W
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head_data,
    output logic         full,
    output logic         empty
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;
    logic         do_pop;
    logic         do_push;

    assign empty   = (count == 2'd0);
    assign full    = (count == 2'd2);
    assign do_pop  = pop && !empty;
    // When full, the slot being written is the head being popped this cycle.
    assign do_push = push && (!full || do_pop);

    assign head_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_result_stage.sv
// rtl/alu_result_stage.sv - ALU result capture stage with MUL/DIV wait and 2-entry buffer
// Ports: iClk, nRst (sync active-low); iStart/iCtrl request a capture of
// iC_hi/iC_lo/iZero/iNeg; oBusy while waiting on MUL/DIV; oValid/iReady
// pop the head shown on oZ_hi/oZ_lo/oZero/oNeg; iZHiOut/iZLoOut drive the
// head onto oBus/oBusEn; oDropErr is a sticky lost-capture flag.
module alu_result_stage
    import alu_result_stage_pkg::*;
#(
    parameter int MULDIV_WAIT = MULDIV_WAIT_DEFAULT
) (
    input  logic        iClk,
    input  logic        nRst,
    input  logic        iStart,
    input  logic [3:0]  iCtrl,
    input  logic [31:0] iC_hi,
    input  logic [31:0] iC_lo,
    input  logic        iZero,
    input  logic        iNeg,
    output logic        oBusy,
    output logic        oValid,
    input  logic        iReady,
    output logic [31:0] oZ_hi,
    output logic [31:0] oZ_lo,
    output logic        oZero,
    output logic        oNeg,
    input  logic        iZHiOut,
    input  logic        iZLoOut,
    output logic [31:0] oBus,
    output logic        oBusEn,
    output logic        oDropErr
);

    stage_state_e        state;
    logic [3:0]          cnt;
    logic [3:0]          ctrl_q;
    logic                start_plain;
    logic                wait_done;
    logic                push;
    logic                pop;
    logic                full;
    logic                empty;
    logic                push_dropped;
    logic [RESULT_W-1:0] head;

    assign start_plain  = (state == ST_IDLE) && iStart && !is_muldiv(iCtrl);
    assign wait_done    = (state == ST_WAIT) && (cnt == 4'd0) && is_muldiv(ctrl_q);
    assign push         = start_plain || wait_done;
    assign pop          = iReady && oValid;
    assign push_dropped = push && full && !pop;

    result_fifo2 #(.W(RESULT_W)) u_fifo (
        .clk       (iClk),
        .resetn    (nRst),
        .push      (push),
        .push_data ({iC_hi, iC_lo, iZero, iNeg}),
        .pop       (pop),
        .head_data (head),
        .full      (full),
        .empty     (empty)
    );

    always_ff @(posedge iClk) begin
        if (!nRst) begin
            state    <= ST_IDLE;
            cnt      <= 4'd0;
            ctrl_q   <= ALU_ADD;
            oBusy    <= 1'b0;
            oDropErr <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (iStart && is_muldiv(iCtrl)) begin
                        state  <= ST_WAIT;
                        cnt    <= 4'(MULDIV_WAIT - 1);
                        ctrl_q <= iCtrl;
                        oBusy  <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= ST_IDLE;
                        oBusy <= 1'b0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
            if ((state == ST_WAIT && iStart) || push_dropped) begin
                oDropErr <= 1'b1;
            end
        end
    end

    assign oValid = !empty;
    assign oZ_hi  = head[65:34];
    assign oZ_lo  = head[33:2];
    assign oZero  = head[1];
    assign oNeg   = head[0];
    assign oBusEn = (iZHiOut || iZLoOut) && oValid;

    // Hi select wins when both selects are asserted.
    always_comb begin
        oBus = 32'd0;
        if (oBusEn) begin
            oBus = iZHiOut ? oZ_hi : oZ_lo;
        end
    end

endmodule

// File: tb/tb_alu_result_stage.sv
// tb/tb_alu_result_stage.sv - scoreboard bench for alu_result_stage
module tb_alu_result_stage;

    logic        iClk = 1'b0;
    logic        nRst;
    logic        iStart;
    logic [3:0]  iCtrl;
    logic [31:0] iC_hi;
    logic [31:0] iC_lo;
    logic        iZero;
    logic        iNeg;
    logic        oBusy;
    logic        oValid;
    logic        iReady;
    logic [31:0] oZ_hi;
    logic [31:0] oZ_lo;
    logic        oZero;
    logic        oNeg;
    logic        iZHiOut;
    logic        iZLoOut;
    logic [31:0] oBus;
    logic        oBusEn;
    logic        oDropErr;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_MUL = 4'd9;
    localparam logic [3:0] OP_DIV = 4'd10;

    int total = 0;
    int bad   = 0;
    logic [65:0] exp_q [$];

    always #5 iClk = ~iClk;

    alu_result_stage #(.MULDIV_WAIT(3)) dut (
        .iClk     (iClk),
        .nRst     (nRst),
        .iStart   (iStart),
        .iCtrl    (iCtrl),
        .iC_hi    (iC_hi),
        .iC_lo    (iC_lo),
        .iZero    (iZero),
        .iNeg     (iNeg),
        .oBusy    (oBusy),
        .oValid   (oValid),
        .iReady   (iReady),
        .oZ_hi    (oZ_hi),
        .oZ_lo    (oZ_lo),
        .oZero    (oZero),
        .oNeg     (oNeg),
        .iZHiOut  (iZHiOut),
        .iZLoOut  (iZLoOut),
        .oBus     (oBus),
        .oBusEn   (oBusEn),
        .oDropErr (oDropErr)
    );

    task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every accepted pop is checked against the scoreboard.
    always @(negedge iClk) begin
        if (nRst === 1'b1 && oValid === 1'b1 && iReady === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("pop_unexpected", 66'd1, 66'd0);
            end else begin
                chk("pop_data", {oZ_hi, oZ_lo, oZero, oNeg}, exp_q.pop_front());
            end
        end
    end

    task automatic cyc();
        @(posedge iClk);
        #1;
    endtask

    task automatic do_reset();
        nRst = 1'b0; iStart = 1'b0; iReady = 1'b0;
        cyc();
        nRst = 1'b1;
    endtask

    task automatic set_alu(input logic [3:0] op, input logic [31:0] hi, input logic [31:0] lo,
                           input logic z, input logic n);
        iCtrl = op; iC_hi = hi; iC_lo = lo; iZero = z; iNeg = n;
    endtask

    task automatic add_start(input logic [31:0] hi, input logic [31:0] lo, input logic z,
                             input logic n, input logic expect_store);
        iStart = 1'b1;
        set_alu(OP_ADD, hi, lo, z, n);
        if (expect_store) exp_q.push_back({hi, lo, z, n});
        cyc();
        iStart = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        nRst = 1'b0; iStart = 1'b0; iReady = 1'b0; iZHiOut = 1'b1; iZLoOut = 1'b0;
        set_alu(OP_ADD, 32'd0, 32'd0, 1'b0, 1'b0);
        cyc(); cyc();
        chk("rst_valid", 66'(oValid), 66'd0);
        chk("rst_busy", 66'(oBusy), 66'd0);
        chk("rst_drop", 66'(oDropErr), 66'd0);
        chk("rst_data", {oZ_hi, oZ_lo, oZero, oNeg}, 66'd0);
        chk("rst_bus", {33'd0, oBusEn, oBus}, 66'd0);
        nRst = 1'b1; iZHiOut = 1'b0;
        cyc();

        // Simple ADD capture and pop
        add_start(32'd0, 32'h5, 1'b0, 1'b0, 1'b1);
        chk("add_valid", 66'(oValid), 66'd1);
        chk("add_lo", 66'(oZ_lo), 66'h5);
        chk("add_zero", 66'(oZero), 66'd0);
        iReady = 1'b1; cyc(); iReady = 1'b0;
        chk("add_popped", 66'(oValid), 66'd0);

        // MUL with wait of 3: busy 3 cycles, result sampled in last wait cycle
        iStart = 1'b1; set_alu(OP_MUL, 32'hdead, 32'hbeef, 1'b1, 1'b1);
        exp_q.push_back({32'h1, 32'h8000_0000, 1'b0, 1'b0});
        cyc();
        iStart = 1'b0;
        set_alu(OP_MUL, 32'h1, 32'h8000_0000, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("mul_busy", 66'(oBusy), 66'd1);
            chk("mul_not_valid", 66'(oValid), 66'd0);
            cyc();
        end
        chk("mul_busy_done", 66'(oBusy), 66'd0);
        chk("mul_valid", 66'(oValid), 66'd1);
        chk("mul_hi", 66'(oZ_hi), 66'h1);
        chk("mul_lo", 66'(oZ_lo), 66'h8000_0000);
        iReady = 1'b1; cyc(); iReady = 1'b0;
        chk("mul_drop_clear", 66'(oDropErr), 66'd0);

        // Overflow: third capture dropped
        do_reset();
        add_start(32'd0, 32'd1, 1'b0, 1'b0, 1'b1);
        add_start(32'd0, 32'd2, 1'b0, 1'b0, 1'b1);
        add_start(32'd0, 32'd3, 1'b0, 1'b0, 1'b0);
        chk("ovf_drop", 66'(oDropErr), 66'd1);
        chk("ovf_head", 66'(oZ_lo), 66'd1);
        iReady = 1'b1; cyc(); cyc(); iReady = 1'b0;
        chk("ovf_empty", 66'(oValid), 66'd0);

        // Full buffer with simultaneous push and pop
        do_reset();
        add_start(32'd0, 32'd1, 1'b0, 1'b0, 1'b1);
        add_start(32'hffff_ffff, 32'hffff_fffe, 1'b0, 1'b1, 1'b1);
        iReady = 1'b1;
        add_start(32'd0, 32'd3, 1'b1, 1'b0, 1'b1);
        iReady = 1'b0;
        chk("fp_valid", 66'(oValid), 66'd1);
        chk("fp_drop", 66'(oDropErr), 66'd0);
        chk("fp_head", {oZ_hi, oZ_lo, oZero, oNeg}, {32'hffff_ffff, 32'hffff_fffe, 1'b0, 1'b1});
        iReady = 1'b1; cyc();
        chk("fp_second", 66'(oValid), 66'd1);
        cyc(); iReady = 1'b0;
        chk("fp_empty", 66'(oValid), 66'd0);

        // Bus mux priority and empty behaviour
        do_reset();
        add_start(32'hAAAA_0000, 32'h5555, 1'b0, 1'b0, 1'b1);
        iZHiOut = 1'b1; iZLoOut = 1'b1; #1;
        chk("bus_both", {33'd0, oBusEn, oBus}, {33'd0, 1'b1, 32'hAAAA_0000});
        iZHiOut = 1'b0; #1;
        chk("bus_lo", {33'd0, oBusEn, oBus}, {33'd0, 1'b1, 32'h5555});
        iZHiOut = 1'b0; iZLoOut = 1'b0; #1;
        chk("bus_none", {33'd0, oBusEn, oBus}, 66'd0);
        iReady = 1'b1; cyc(); iReady = 1'b0;
        iZHiOut = 1'b1; iZLoOut = 1'b1; #1;
        chk("bus_empty", {33'd0, oBusEn, oBus}, 66'd0);
        iZHiOut = 1'b0; iZLoOut = 1'b0;

        // DIV, start ignored in WAIT, then reset mid-wait abandons the capture
        do_reset();
        iStart = 1'b1; set_alu(OP_DIV, 32'h7, 32'h9, 1'b0, 1'b0);
        cyc();
        chk("div_busy", 66'(oBusy), 66'd1);
        set_alu(OP_ADD, 32'h0, 32'h44, 1'b0, 1'b0);
        cyc();
        iStart = 1'b0;
        chk("wait_start_drop", 66'(oDropErr), 66'd1);
        chk("wait_start_ignored", 66'(oValid), 66'd0);
        nRst = 1'b0; iStart = 1'b1; iReady = 1'b1;
        cyc();
        chk("div_rst_busy", 66'(oBusy), 66'd0);
        chk("div_rst_valid", 66'(oValid), 66'd0);
        chk("div_rst_drop", 66'(oDropErr), 66'd0);
        nRst = 1'b1; iStart = 1'b0; iReady = 1'b0;
        set_alu(OP_DIV, 32'h1, 32'h2, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cyc();
        chk("div_no_write", 66'(oValid), 66'd0);
        chk("div_idle", 66'(oBusy), 66'd0);

        chk("scoreboard_drained", 66'(exp_q.size()), 66'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
